upcounter: RTL and testbench
============================

UPCOUNTER -- requirements
Module: upcounter

Interface
REQ-001 The module SHALL take parameter N, default 4, setting counter width in bits; legal range 1..32.
REQ-002 The module SHALL take parameter RESET_VALUE, default 0, loaded into q on reset; truncated to N bits.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port q, output, N bits, SHALL be the registered count value.
REQ-006 Port order SHALL be clk, reset, q, so positional instantiation upcounter #(.N(k)) u(clk, reset, q) is valid.

Function
REQ-007 On each rising clk edge with reset low, q SHALL become q+1, modulo 2^N.
REQ-008 Increment latency SHALL be one clock: a value change appears only after a rising edge, never combinationally.
REQ-009 Wrap-around: q = 2^N-1 with reset low SHALL go to 0 on the next rising edge, with no stall or glitch cycle.
REQ-010 q SHALL be driven directly from the state register, with no combinational logic on the output path.
REQ-011 Arithmetic SHALL be unsigned, N bits wide; no carry-out is exposed.
REQ-012 q SHALL hold its value between rising edges, regardless of activity on reset.
REQ-013 Before the first reset edge, q is undefined (X in simulation); no initial-value dependence is permitted.

Reset
REQ-014 With reset high at a rising clk edge, q SHALL load RESET_VALUE (0 by default) on that edge, taking priority over increment.
REQ-015 With reset held high for multiple cycles, q SHALL remain at RESET_VALUE every cycle.
REQ-016 Reset deasserted between edges SHALL leave the counter counting from RESET_VALUE: q = RESET_VALUE+1 on the first rising edge with reset low.
REQ-017 Reset asserted mid-count, including at q = 2^N-1, SHALL load RESET_VALUE on that edge; no increment occurs in that cycle.
REQ-018 A reset pulse between rising edges SHALL have no effect on q, because reset is synchronous.

Configuration
REQ-019 Macro UPCOUNTER_SATURATE_EN SHALL select the terminal-count behaviour.
REQ-020 With UPCOUNTER_SATURATE_EN defined, q SHALL stop at 2^N-1 and hold there until reset.
REQ-021 With UPCOUNTER_SATURATE_EN undefined, which is the default build, q SHALL wrap to 0 per REQ-009.
REQ-022 UPCOUNTER_SATURATE_EN SHALL not change reset behaviour or port list.

Verification
REQ-023 N=4, clock period 1000, reset high for 10 cycles -> q = 0 at every rising edge during reset.
REQ-024 N=4, reset released on a falling edge -> q = 1, 2, 3 ... on successive rising edges, one step per cycle.
REQ-025 N=4, default build, 50 cycles after reset release -> q passes 15 and then reads 0; at cycle 50, q = 50 mod 16 = 2.
REQ-026 N=4, reset reasserted when q = 9 -> q = 0 at that edge, and q = 1 one edge after release.
REQ-027 N=4, UPCOUNTER_SATURATE_EN defined, 20 cycles after release -> q reaches 15 and stays at 15.
REQ-028 N=8, RESET_VALUE=250, default build -> after release q = 251 ... 255, then 0.

Source files
------------

// File: rtl/upcounter.sv
// rtl/upcounter.sv - N-bit synchronous up-counter; UPCOUNTER_SATURATE_EN selects hold-at-terminal instead of wrap
module upcounter #(
   parameter int unsigned N           = 4,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic         clk,
   input  logic         reset,
   output logic [N-1:0] q
);

   localparam logic [N-1:0] RESET_Q  = N'(RESET_VALUE);
   localparam logic [N-1:0] TERMINAL = '1;
   localparam logic [N-1:0] ONE      = N'(1);

   logic [N-1:0] count_q;
   logic [N-1:0] count_d;

   always_comb begin
      count_d = count_q + ONE;
`ifdef UPCOUNTER_SATURATE_EN
      if (count_q == TERMINAL) begin
         count_d = count_q;
      end
`else
      // The N-bit add drops the carry, so all-ones rolls over to zero.
      if (count_q == TERMINAL) begin
         count_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= RESET_Q;
      end else begin
         count_q <= count_d;
      end
   end

   assign q = count_q;

endmodule

// File: tb/tb_upcounter.sv
// tb/tb_upcounter.sv - scoreboard bench for upcounter (N=4 default and N=8 with RESET_VALUE=250)
module tb_upcounter;

   logic       clk;
   logic       reset;
   logic [3:0] q4;
   logic [7:0] q8;

   int checks = 0;
   int errors = 0;

   int m4;
   int m8;
   logic [3:0] exp4_q[$];
   logic [7:0] exp8_q[$];

   upcounter #(.N(4)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .q     (q4)
   );

   upcounter #(.N(8), .RESET_VALUE(250)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .q     (q8)
   );

   initial clk = 1'b0;
   always #500 clk = ~clk;

   function automatic int next_val(input int cur, input int maxv, input int rst_val, input logic r);
      if (r) return rst_val;
`ifdef UPCOUNTER_SATURATE_EN
      if (cur == maxv) return maxv;
      return cur + 1;
`else
      return (cur + 1) % (maxv + 1);
`endif
   endfunction

   // Drive reset on the falling edge, predict, then compare just after the rising edge.
   task automatic step(input logic r, input string tag);
      logic [3:0] e4;
      logic [7:0] e8;
      @(negedge clk);
      reset = r;
      m4 = next_val(m4, 15, 0, r);
      m8 = next_val(m8, 255, 250, r);
      exp4_q.push_back(4'(m4));
      exp8_q.push_back(8'(m8));
      @(posedge clk);
      #1;
      e4 = exp4_q.pop_front();
      e8 = exp8_q.pop_front();
      checks++;
      assert (q4 === e4) else begin
         errors++;
         $error("FAIL %s q4 observed=%0d expected=%0d", tag, q4, e4);
      end
      checks++;
      assert (q8 === e8) else begin
         errors++;
         $error("FAIL %s q8 observed=%0d expected=%0d", tag, q8, e8);
      end
   endtask

   // A reset pulse that falls entirely between rising edges must not disturb q.
   task automatic glitch_check();
      #200;
      reset = 1'b1;
      #100;
      reset = 1'b0;
      #50;
      checks++;
      assert (q4 === 4'(m4)) else begin
         errors++;
         $error("FAIL glitch q4 observed=%0d expected=%0d", q4, 4'(m4));
      end
      checks++;
      assert (q8 === 8'(m8)) else begin
         errors++;
         $error("FAIL glitch q8 observed=%0d expected=%0d", q8, 8'(m8));
      end
   endtask

   initial begin
      reset = 1'b1;
      m4 = 0;
      m8 = 250;

      for (int i = 0; i < 10; i++) step(1'b1, "reset_hold");

      for (int i = 1; i <= 50; i++) step(1'b0, "count");
      glitch_check();

      while (m4 != 9) step(1'b0, "to_nine");
      step(1'b1, "reset_at_nine");
      step(1'b0, "after_nine_release");
      step(1'b0, "after_nine_count");

      while (m4 != 15) step(1'b0, "to_terminal");
      glitch_check();
      step(1'b1, "reset_at_terminal");
      step(1'b0, "after_terminal_release");

      for (int i = 0; i < 20; i++) step(1'b0, "long_run");
      glitch_check();
      step(1'b1, "final_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
